// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and defaults for the PE MAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int PE_ADDR_W   = 8;
    localparam int PE_PIPE_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } pe_mac_seq_state_t;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : pe_delay_line
//  Description : DEPTH-stage shift register with synchronous clear. Besides the
//                delayed output it flags when every stage except the output
//                stage is empty, i.e. the line will be empty after this cycle
//                provided nothing new is shifted in.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_last_only
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per cycle; reset or clear flushes every stage
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_single
            // Only the output stage exists, so nothing is left behind it
            assign o_last_only = 1'b1;
        end else begin : g_multi
            logic w_inner_busy;

            // OR of every stage ahead of the output stage
            always_comb begin
                w_inner_busy = 1'b0;
                for (int i = 0; i < DEPTH - 1; i++) begin
                    w_inner_busy = w_inner_busy | (|r_stage[i]);
                end
            end

            assign o_last_only = ~w_inner_busy;
        end
    endgenerate

endmodule : pe_delay_line
`default_nettype wire

// File: rtl/pe_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_seq
//  Description : Sequencer for the PE multiply-accumulate datapath. Clears the
//                accumulator, issues len sequential operand reads, enables
//                accumulation PIPE_LAT cycles later and hands the result out
//                with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_seq
    import pe_pkg::*;
#(
    parameter int ADDR_W   = PE_ADDR_W,
    parameter int LEN_W    = ADDR_W + 1,
    parameter int PIPE_LAT = PE_PIPE_LAT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              acc_clr_o,
    output logic              acc_en_o,
    output logic              res_valid_o,
    output logic              done_o
);

    // Largest job the address space can hold
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(2 ** ADDR_W);

    pe_mac_seq_state_t r_state;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              r_done;

    logic [LEN_W-1:0]  w_len_clamped;
    logic              w_last_rd;
    logic              w_dl_last_only;

    assign w_len_clamped = (len_i > c_max_len) ? c_max_len : len_i;

    // The counter is compared at full job width so a 2**ADDR_W job ends on the
    // all-ones address and the counter then simply wraps to zero
    assign w_last_rd = (LEN_W'(r_cnt) == (r_len - LEN_W'(1)));

    // Control FSM with address/length bookkeeping; abort outranks everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_addr_hold <= '0;
            r_done      <= 1'b0;
        end else if (abort_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_len   <= w_len_clamped;
                            r_state <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_cnt       <= r_cnt + ADDR_W'(1);
                    r_addr_hold <= r_cnt;
                    if (w_last_rd) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the final in-flight read reaches the output stage
                    if (w_dl_last_only) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready_i) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read enables travel down the line to become accumulate enables
    pe_delay_line #(
        .WIDTH (1),
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clr       (abort_i),
        .i_d         (rd_en_o),
        .o_q         (acc_en_o),
        .o_last_only (w_dl_last_only)
    );

    assign busy_o      = (r_state != ST_IDLE);
    assign rd_en_o     = (r_state == ST_RUN);
    assign rd_addr_o   = rd_en_o ? r_cnt : r_addr_hold;
    assign acc_clr_o   = (r_state == ST_CLEAR);
    assign res_valid_o = (r_state == ST_OUT);
    assign done_o      = r_done;

endmodule : pe_mac_seq
`default_nettype wire

// File: tb/tb_pe_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_mac_seq
//  Description : Directed and randomised job bench for pe_mac_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_seq;

    localparam int ADDR_W   = 8;
    localparam int LEN_W    = 9;
    localparam int PIPE_LAT = 2;

    typedef struct {
        int len;
        int delay;       // OUT cycles with ready held low
        bit pulse;       // pulse start_i during OUT
        int reads;
        int clr;
        int acc_first;
        int valid_first;
        int vcnt;
        int done_cyc;
        bit busy;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              res_ready;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              res_valid;
    logic              done;

    int n_total = 0;
    int n_bad   = 0;
    int n_jobs  = 0;
    int n_dones = 0;

    pe_mac_seq #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .len_i       (len),
        .abort_i     (abort),
        .res_ready_i (res_ready),
        .busy_o      (busy),
        .rd_en_o     (rd_en),
        .rd_addr_o   (rd_addr),
        .acc_clr_o   (acc_clr),
        .acc_en_o    (acc_en),
        .res_valid_o (res_valid),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a job at the current cycle boundary and observe it through done_o
    task automatic run_job(input string tag, input vec_t v);
        int cyc, reads, clr, acc, acc_first, valid_first, vcnt, done_cyc;
        int addr_err, clr_overlap, exp_addr, last_addr, busy_any, idle_busy;
        reads = 0; clr = 0; acc = 0; acc_first = -1; valid_first = -1;
        vcnt = 0; done_cyc = -1; addr_err = 0; clr_overlap = 0;
        exp_addr = 0; busy_any = 0; idle_busy = 0;
        last_addr = int'(rd_addr);
        n_jobs++;
        start = 1'b1;
        len   = LEN_W'(v.len);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (cyc = 1; cyc < 400; cyc++) begin
            if (rd_en) begin
                if (int'(rd_addr) != exp_addr) addr_err++;
                exp_addr  = (exp_addr + 1) & 255;
                last_addr = int'(rd_addr);
                reads++;
            end else if (int'(rd_addr) != last_addr) begin
                addr_err++;
            end
            if (acc_en) begin
                if (acc_first < 0) acc_first = cyc;
                if (acc_clr) clr_overlap++;
                acc++;
            end
            if (acc_clr) clr++;
            if (res_valid) begin
                if (valid_first < 0) valid_first = cyc;
                vcnt++;
            end
            if (busy) busy_any = 1;
            if (done) begin
                done_cyc = cyc;
                n_dones++;
                break;
            end
            res_ready = res_valid && (vcnt > v.delay);
            if (v.pulse && res_valid && vcnt == 2) begin
                start = 1'b1;
                len   = LEN_W'(5);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        res_ready = 1'b0;
        start     = 1'b0;
        if (done_cyc < 0) chk({tag, " timeout"}, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (busy || done) idle_busy++;
        end
        chk({tag, " reads"},       reads,       v.reads);
        chk({tag, " addr_err"},    addr_err,    0);
        chk({tag, " acc_count"},   acc,         v.reads);
        chk({tag, " acc_first"},   acc_first,   v.acc_first);
        chk({tag, " clr_count"},   clr,         v.clr);
        chk({tag, " clr_overlap"}, clr_overlap, 0);
        chk({tag, " valid_first"}, valid_first, v.valid_first);
        chk({tag, " valid_cnt"},   vcnt,        v.vcnt);
        chk({tag, " done_cyc"},    done_cyc,    v.done_cyc);
        chk({tag, " busy_seen"},   busy_any,    int'(v.busy));
        chk({tag, " idle_after"},  idle_busy,   0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outputs"},
            int'({busy, rd_en, acc_clr, acc_en, res_valid, done}), 0);
        chk({tag, " rd_addr"}, int'(rd_addr), 0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; res_ready = 1'b0;

        //             len  dly pls reads clr accf vfirst vcnt done busy
        tbl[0] = '{    4,   0,  0,    4,  1,   4,    8,   1,    9, 1};
        tbl[1] = '{    0,   0,  0,    0,  0,  -1,   -1,   0,    1, 0};
        tbl[2] = '{    1,   0,  0,    1,  1,   4,    5,   1,    6, 1};
        tbl[3] = '{  256,   0,  0,  256,  1,   4,  260,   1,  261, 1};
        tbl[4] = '{  300,   0,  0,  256,  1,   4,  260,   1,  261, 1};
        tbl[5] = '{    4,   5,  1,    4,  1,   4,    8,   6,   14, 1};
        tbl[6] = '{    3,   2,  0,    3,  1,   4,    7,   3,   10, 1};

        // Reset state
        tick(); tick(); tick();
        chk_all_zero("reset_held");
        rst = 1'b0;
        tick();
        chk_all_zero("reset_released");

        for (int i = 0; i < 7; i++) begin
            run_job($sformatf("vec%0d", i), tbl[i]);
        end

        // Abort on the third RUN cycle of an 8-element job
        start = 1'b1; len = LEN_W'(8);
        tick();
        start = 1'b0;          // cycle 1: CLEAR
        tick(); tick(); tick(); // cycle 4: third RUN cycle
        chk("abort rd_en_before", int'(rd_en), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy",  int'(busy),      0);
        chk("abort acc",   int'(acc_en),    0);
        chk("abort valid", int'(res_valid), 0);
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < 12; k++) begin
                if (done || acc_en || rd_en || busy) stray++;
                tick();
            end
            chk("abort quiet", stray, 0);
        end
        // A fresh job after the abort still addresses from zero
        run_job("post_abort", tbl[0]);

        // Abort beats a simultaneous start
        start = 1'b1; abort = 1'b1; len = LEN_W'(4);
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start busy", int'(busy), 0);
        tick();
        chk("abort_vs_start done", int'(done), 0);

        // Reset in the middle of a job zeroes everything
        start = 1'b1; len = LEN_W'(8);
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        run_job("post_reset", tbl[2]);

        // Back-to-back random jobs against a small timing model
        n_jobs = 0; n_dones = 0;
        for (int j = 0; j < 16; j++) begin
            rv.len         = int'($urandom_range(1, 256));
            rv.delay       = int'($urandom_range(0, 3));
            rv.pulse       = 1'b0;
            rv.reads       = rv.len;
            rv.clr         = 1;
            rv.acc_first   = 2 + PIPE_LAT;
            rv.valid_first = rv.len + 2 + PIPE_LAT;
            rv.vcnt        = rv.delay + 1;
            rv.done_cyc    = rv.valid_first + rv.delay + 1;
            rv.busy        = 1'b1;
            run_job($sformatf("rand%0d_len%0d", j, rv.len), rv);
        end
        chk("rand done_count", n_dones, n_jobs);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pe_mac_seq
`default_nettype wire
